// File: rtl/sign_shift_pipe.sv
// sign_shift_pipe: pipelined, sign-preserving barrel shifter with four modes
// (pass, left wrap, left saturate, rounding arithmetic right shift), per-beat
// overflow flag, sticky overflow and valid/ready flow control on both sides.
// The whole shift is resolved in front of stage 0; the remaining stages only
// carry the result, so the observable latency is PIPE cycles.
module sign_shift_pipe #(
    parameter int WIDTH = 12,
    parameter int SHW   = 4,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_WRAP = 2'b01;
    localparam logic [1:0] MODE_SAT  = 2'b10;
    localparam logic [1:0] MODE_RND  = 2'b11;

    localparam logic [SHW-1:0] SMAX = SHW'(WIDTH - 1);

    // shift datapath signals
    logic [SHW-1:0]      sh;
    logic [WIDTH-1:0]    lsh;
    logic [WIDTH-1:0]    back;
    logic [WIDTH-1:0]    wrap;
    logic [WIDTH-1:0]    sat;
    logic                lovf;
    logic [WIDTH:0]      rnd;
    logic signed [WIDTH:0] sum;
    logic [WIDTH-1:0]    res_rnd;
    logic [WIDTH-1:0]    res;
    logic                res_ovf;

    // pipeline state
    logic [PIPE-1:0]            vld_q, vld_d;
    logic [PIPE-1:0][WIDTH-1:0] dat_q, dat_d;
    logic [PIPE-1:0]            ovf_q, ovf_d;
    logic [PIPE-1:0]            load;
    logic [PIPE-1:0]            src_v;
    logic [PIPE-1:0][WIDTH-1:0] src_dat;
    logic [PIPE-1:0]            src_ovf;
    logic                       sticky_q, sticky_d;

    // Combinational shift: clamp the amount, then build every mode's result.
    // Overflow test: shifting left then arithmetically back only restores x
    // when all bits pushed past the sign position matched the sign.
    always_comb begin
        sh      = (in_shamt > SMAX) ? SMAX : in_shamt;
        lsh     = in_data << sh;
        back    = $signed(lsh) >>> sh;
        lovf    = (back != in_data);
        wrap    = {in_data[WIDTH-1], lsh[WIDTH-2:0]};
        sat     = in_data[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        rnd     = (sh == '0) ? '0 : ((WIDTH+1)'(1) << (sh - SHW'(1)));
        sum     = $signed({in_data[WIDTH-1], in_data}) + $signed(rnd);
        res_rnd = WIDTH'(sum >>> sh);
        res     = in_data;
        res_ovf = 1'b0;
        case (in_mode)
            MODE_PASS: begin
                res     = in_data;
                res_ovf = 1'b0;
            end
            MODE_WRAP: begin
                res     = wrap;
                res_ovf = lovf;
            end
            MODE_SAT: begin
                res     = lovf ? sat : wrap;
                res_ovf = lovf;
            end
            MODE_RND: begin
                res     = res_rnd;
                res_ovf = 1'b0;
            end
            default: ;
        endcase
    end

    // Each stage's source: stage 0 takes the fresh beat, later stages take the one above.
    for (genvar g = 0; g < PIPE; g++) begin : g_src
        if (g == 0) begin : g_head
            assign src_v[g]   = in_valid;
            assign src_dat[g] = res;
            assign src_ovf[g] = res_ovf;
        end else begin : g_body
            assign src_v[g]   = vld_q[g-1];
            assign src_dat[g] = dat_q[g-1];
            assign src_ovf[g] = ovf_q[g-1];
        end
    end

    // Stage load enables: a stage loads when empty or when its beat moves on,
    // which lets bubbles collapse and makes in_ready depend on out_ready.
    always_comb begin
        load[PIPE-1] = ~vld_q[PIPE-1] | out_ready;
        for (int i = PIPE - 2; i >= 0; i--) begin
            load[i] = ~vld_q[i] | load[i+1];
        end
    end

    // Next-state for the stage registers and sticky flag (set beats clear).
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        ovf_d = ovf_q;
        for (int i = 0; i < PIPE; i++) begin
            if (load[i]) begin
                vld_d[i] = src_v[i];
                if (src_v[i]) begin
                    dat_d[i] = src_dat[i];
                    ovf_d[i] = src_ovf[i];
                end
            end
        end
        if (out_valid & out_ready & out_ovf) begin
            sticky_d = 1'b1;
        end else if (ovf_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Stage registers; reset discards every in-flight beat at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            dat_q    <= '0;
            ovf_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            dat_q    <= dat_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign in_ready   = load[0];
    assign out_valid  = vld_q[PIPE-1];
    assign out_data   = dat_q[PIPE-1];
    assign out_ovf    = ovf_q[PIPE-1];
    assign ovf_sticky = sticky_q;

endmodule
